// File: rtl/rom_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_addr_sequencer
//  Description : ROM address generator with manual step, prescaled auto-run
//                and direct switch load, plus state/strobe outputs for the LCD.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_addr_sequencer #(
    parameter int ADDR_WIDTH = 2,
    parameter int TICK_DIV   = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  run,
    input  logic                  once,
    input  logic                  step,
    input  logic                  dir,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    output logic                  wrap,
    output logic [1:0]            state
);

    localparam int                    c_PRESC_W    = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0]  c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX   = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = ADDR_WIDTH'(1);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RUN  = 2'b01;
    localparam logic [1:0] c_DONE = 2'b10;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;
    logic                  r_wrap;
    logic [1:0]            r_state;
    logic [c_PRESC_W-1:0]  r_presc;
    logic                  r_step_q;

    logic                  w_step_rise;
    logic                  w_tick;
    logic [ADDR_WIDTH-1:0] w_adv_addr;
    logic                  w_adv_wrap;

    always_comb begin
        w_step_rise = step & ~r_step_q;
        w_tick      = (r_state == c_RUN) && (r_presc == c_PRESC_LAST);
        w_adv_addr  = dir ? (r_addr - c_ADDR_ONE) : (r_addr + c_ADDR_ONE);
        w_adv_wrap  = dir ? (r_addr == '0) : (r_addr == c_ADDR_MAX);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_state  <= c_IDLE;
            r_presc  <= '0;
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;

            // Load wins over any advance and is honoured in every state.
            if (load) begin
                r_addr  <= load_addr;
                r_valid <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    r_presc <= '0;
                    if (!load && w_step_rise) begin
                        r_addr  <= w_adv_addr;
                        r_valid <= 1'b1;
                        r_wrap  <= w_adv_wrap;
                    end
                    if (run) begin
                        r_state <= c_RUN;
                    end
                end

                c_RUN: begin
                    if (!run) begin
                        // A tick landing on the run drop is discarded.
                        r_state <= c_IDLE;
                        r_presc <= '0;
                    end else if (load) begin
                        r_presc <= '0;
                    end else if (w_tick) begin
                        r_addr  <= w_adv_addr;
                        r_valid <= 1'b1;
                        r_wrap  <= w_adv_wrap;
                        r_presc <= '0;
                        if (once && w_adv_wrap) begin
                            r_state <= c_DONE;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                c_DONE: begin
                    r_presc <= '0;
                    if (load || !run) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_presc <= '0;
                end
            endcase
        end
    end

    assign addr       = r_addr;
    assign addr_valid = r_valid;
    assign wrap       = r_wrap;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rom_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_addr_sequencer
//  Description : Directed vector bench for rom_addr_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_addr_sequencer;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RUN  = 2'b01;
    localparam logic [1:0] c_DONE = 2'b10;

    logic       clk_2 = 1'b0;
    logic       reset_n;
    logic       load;
    logic [1:0] load_addr;
    logic       run;
    logic       once;
    logic       step;
    logic       dir;
    logic [1:0] addr;
    logic       addr_valid;
    logic       wrap;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ld;
        logic [1:0] la;
        logic       run;
        logic       once;
        logic       step;
        logic       dir;
        logic [1:0] ea;
        logic       ev;
        logic       ew;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[$];

    rom_addr_sequencer #(
        .ADDR_WIDTH (2),
        .TICK_DIV   (4)
    ) dut (
        .clk_2      (clk_2),
        .reset_n    (reset_n),
        .load       (load),
        .load_addr  (load_addr),
        .run        (run),
        .once       (once),
        .step       (step),
        .dir        (dir),
        .addr       (addr),
        .addr_valid (addr_valid),
        .wrap       (wrap),
        .state      (state)
    );

    always #5 clk_2 = ~clk_2;

    function automatic vec_t mk(input logic ld, input logic [1:0] la, input logic rn,
                                input logic on, input logic st, input logic dr,
                                input logic [1:0] ea, input logic ev, input logic ew,
                                input logic [1:0] es);
        vec_t v;
        v.ld = ld; v.la = la; v.run = rn; v.once = on; v.step = st; v.dir = dr;
        v.ea = ea; v.ev = ev; v.ew = ew; v.es = es;
        return v;
    endfunction

    function automatic void add(input logic ld, input logic [1:0] la, input logic rn,
                                input logic on, input logic st, input logic dr,
                                input logic [1:0] ea, input logic ev, input logic ew,
                                input logic [1:0] es);
        vecs.push_back(mk(ld, la, rn, on, st, dr, ea, ev, ew, es));
    endfunction

    function automatic void add_n(input int n, input logic ld, input logic [1:0] la,
                                  input logic rn, input logic on, input logic st,
                                  input logic dr, input logic [1:0] ea, input logic ev,
                                  input logic ew, input logic [1:0] es);
        for (int i = 0; i < n; i++) add(ld, la, rn, on, st, dr, ea, ev, ew, es);
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h t=%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic check_outs(input int idx, input vec_t v);
        check("addr",       idx, {6'b0, addr},       {6'b0, v.ea});
        check("addr_valid", idx, {7'b0, addr_valid}, {7'b0, v.ev});
        check("wrap",       idx, {7'b0, wrap},       {7'b0, v.ew});
        check("state",      idx, {6'b0, state},      {6'b0, v.es});
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_2);
        load      = v.ld;
        load_addr = v.la;
        run       = v.run;
        once      = v.once;
        step      = v.step;
        dir       = v.dir;
        @(posedge clk_2);
        #1;
        check_outs(idx, v);
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; load_addr = 2'd0; run = 1'b0;
        once = 1'b0; step = 1'b0; dir = 1'b0;

        // Manual stepping: held press yields one advance, wrap both directions
        add(0,0,0,0,1,0, 2'd1,1,0,c_IDLE);
        add_n(4, 0,0,0,0,1,0, 2'd1,0,0,c_IDLE);
        add(0,0,0,0,0,0, 2'd1,0,0,c_IDLE);
        add(0,0,0,0,1,0, 2'd2,1,0,c_IDLE);
        add(0,0,0,0,0,0, 2'd2,0,0,c_IDLE);
        add(0,0,0,0,1,0, 2'd3,1,0,c_IDLE);
        add(0,0,0,0,0,0, 2'd3,0,0,c_IDLE);
        add(0,0,0,0,1,0, 2'd0,1,1,c_IDLE);
        add(0,0,0,0,0,1, 2'd0,0,0,c_IDLE);
        add(0,0,0,0,1,1, 2'd3,1,1,c_IDLE);
        add(0,0,0,0,0,1, 2'd3,0,0,c_IDLE);

        // Free run from 0: advance every 4th edge, step presses ignored
        add(1,0,0,0,0,0, 2'd0,1,0,c_IDLE);
        add(0,0,1,0,0,0, 2'd0,0,0,c_RUN);
        for (int k = 1; k <= 5; k++) begin
            add(0,0,1,0,(k == 2),0, 2'((k - 1) % 4),0,0,c_RUN);
            add_n(2, 0,0,1,0,0,0, 2'((k - 1) % 4),0,0,c_RUN);
            add(0,0,1,0,0,0, 2'(k % 4),1,(k == 4),c_RUN);
        end
        add(0,0,0,0,0,0, 2'd1,0,0,c_IDLE);

        // Single pass from 2 ends in DONE; DONE ignores ticks and steps
        add(1,2,0,0,0,0, 2'd2,1,0,c_IDLE);
        add(0,0,1,1,0,0, 2'd2,0,0,c_RUN);
        add_n(3, 0,0,1,1,0,0, 2'd2,0,0,c_RUN);
        add(0,0,1,1,0,0, 2'd3,1,0,c_RUN);
        add_n(3, 0,0,1,1,0,0, 2'd3,0,0,c_RUN);
        add(0,0,1,1,0,0, 2'd0,1,1,c_DONE);
        add(0,0,1,1,1,0, 2'd0,0,0,c_DONE);
        add_n(7, 0,0,1,1,0,0, 2'd0,0,0,c_DONE);
        add(0,0,0,1,0,0, 2'd0,0,0,c_IDLE);

        // Load beats a simultaneous step rise
        add(1,2,0,0,1,0, 2'd2,1,0,c_IDLE);
        add(0,0,0,0,0,0, 2'd2,0,0,c_IDLE);

        // Load in RUN at prescaler 2 restarts the count
        add(0,0,1,0,0,0, 2'd2,0,0,c_RUN);
        add_n(2, 0,0,1,0,0,0, 2'd2,0,0,c_RUN);
        add(1,1,1,0,0,0, 2'd1,1,0,c_RUN);
        add_n(3, 0,0,1,0,0,0, 2'd1,0,0,c_RUN);
        add(0,0,1,0,0,0, 2'd2,1,0,c_RUN);
        add(0,0,0,0,0,0, 2'd2,0,0,c_IDLE);

        // Held load strobes every cycle even with an unchanged value
        add_n(2, 1,2,0,0,0,0, 2'd2,1,0,c_IDLE);
        add(0,0,0,0,0,0, 2'd2,0,0,c_IDLE);

        // Tick coinciding with run drop is lost
        add(0,0,1,0,0,0, 2'd2,0,0,c_RUN);
        add_n(3, 0,0,1,0,0,0, 2'd2,0,0,c_RUN);
        add_n(2, 0,0,0,0,0,0, 2'd2,0,0,c_IDLE);

        // Decrement in RUN
        add(0,0,1,0,0,1, 2'd2,0,0,c_RUN);
        add_n(3, 0,0,1,0,0,1, 2'd2,0,0,c_RUN);
        add(0,0,1,0,0,1, 2'd1,1,0,c_RUN);
        add(0,0,0,0,0,0, 2'd1,0,0,c_IDLE);

        // Load while in DONE returns to IDLE with the loaded value
        add(1,3,0,0,0,0, 2'd3,1,0,c_IDLE);
        add(0,0,1,1,0,0, 2'd3,0,0,c_RUN);
        add_n(3, 0,0,1,1,0,0, 2'd3,0,0,c_RUN);
        add(0,0,1,1,0,0, 2'd0,1,1,c_DONE);
        add(1,1,1,1,0,0, 2'd1,1,0,c_IDLE);
        add(0,0,0,0,0,0, 2'd1,0,0,c_IDLE);

        // Park at addr 3, prescaler 3 for the reset case
        add(1,3,0,0,0,0, 2'd3,1,0,c_IDLE);
        add(0,0,1,0,0,0, 2'd3,0,0,c_RUN);
        add_n(3, 0,0,1,0,0,0, 2'd3,0,0,c_RUN);

        repeat (2) @(posedge clk_2);
        #1;
        check_outs(-1, mk(0,0,0,0,0,0, 2'd0,0,0,c_IDLE));
        @(negedge clk_2);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset between edges, mid-RUN
        #1;
        reset_n = 1'b0;
        run     = 1'b0;
        #1;
        check_outs(1000, mk(0,0,0,0,0,0, 2'd0,0,0,c_IDLE));
        @(negedge clk_2);
        @(negedge clk_2);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) apply(mk(0,0,0,0,0,0, 2'd0,0,0,c_IDLE), 1001 + i);
        apply(mk(0,0,1,0,0,0, 2'd0,0,0,c_RUN), 1010);
        for (int i = 0; i < 3; i++) apply(mk(0,0,1,0,0,0, 2'd0,0,0,c_RUN), 1011 + i);
        apply(mk(0,0,1,0,0,0, 2'd1,1,0,c_RUN), 1014);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_addr_sequencer.md
Name: rom_addr_sequencer

Overview:
- Address-generation stage directly upstream of the board's small lookup ROM (2-bit address, 3-bit data driving LED[7:5]); replaces the raw switch-driven address.
- Steps the ROM address manually (debounced step input), automatically (prescaled tick), or loads it directly from switches.
- Also exports state/strobe signals for the LCD debug fields.

Parameters:
- ADDR_WIDTH, 2, width of generated ROM address; address space 0..2**ADDR_WIDTH-1.
- TICK_DIV, 4, clocks per automatic address advance in RUN; legal range >= 2.

Ports:
- clk_2  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- load  input  1  level; load load_addr into address
- load_addr  input  ADDR_WIDTH  address to load (board: SWI[3:2])
- run  input  1  level; enables automatic stepping
- once  input  1  level; in RUN, stop after one full pass (on wrap)
- step  input  1  manual step request; acts on rising edge only
- dir  input  1  0 = increment, 1 = decrement
- addr  output  ADDR_WIDTH  registered ROM address
- addr_valid  output  1  one-cycle pulse in the cycle addr holds a newly written value
- wrap  output  1  one-cycle pulse coincident with addr_valid when the advance wrapped
- state  output  2  FSM state for LCD: 00 IDLE, 01 RUN, 10 DONE

Behaviour:
- Reset (reset_n=0, async): addr=0, state=IDLE, prescaler=0, step edge register=0, addr_valid=0, wrap=0. Release is sampled on the next clk_2 edge. Reset mid-RUN aborts immediately; no pending tick survives.
- Step edge detect: step_q registers step each cycle. step_rise = step & ~step_q. A held step produces exactly one rise.
- Advance: if dir=0, addr+1; if dir=1, addr-1, modulo 2**ADDR_WIDTH.
  - wrap=1 on an advance from max to 0 (dir=0) or from 0 to max (dir=1).
  - Every advance and every load writes addr and pulses addr_valid the cycle after the triggering edge (latency 1).
- Priority per cycle: load > step_rise > tick. Only one address update per cycle.
- load: writes addr=load_addr; wrap=0; prescaler cleared to 0.
  - Valid in any state.
  - In DONE, load also moves state to IDLE.
  - addr_valid pulses on every load cycle, even if the value is unchanged, and for every cycle load is held.
- FSM:
  - IDLE:
    - step_rise advances addr.
    - run=1 moves to RUN with prescaler=0.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1. The tick fires when the prescaler equals TICK_DIV-1; the prescaler then returns to 0 and addr advances.
    - First advance occurs TICK_DIV cycles after entering RUN.
    - step_rise is ignored in RUN (no effect, not queued).
    - run=0 moves to IDLE, prescaler=0. If a tick coincides with run=0, the tick is dropped.
    - If once=1 and the tick's advance wraps, addr takes the wrapped value, wrap pulses, and state moves to DONE.
    - A load in RUN suppresses that cycle's tick, and the prescaler restarts from 0.
  - DONE:
    - addr frozen; ticks and steps ignored.
    - run=0 moves to IDLE. load moves to IDLE with the load applied.
- dir and once are sampled at the tick/step edge; changing them mid-count is legal and takes effect at the next advance.
- Outputs addr, addr_valid, wrap and state are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then step 0->1 held 5 cycles with dir=0 -> addr=1, exactly one addr_valid pulse one cycle after the rising edge; second press -> addr=2.
- addr=3, dir=0, step press -> addr=0, wrap=1 and addr_valid=1 in the same cycle. Then dir=1, press -> addr=3, wrap=1.
- run=1 at cycle 0 from addr=0, TICK_DIV=4, once=0 -> addr values 1,2,3,0,1 at cycles 4,8,12,16,20; wrap only at cycle 16; state=01 throughout.
- run=1, once=1 from addr=2 -> advances to 3 at cycle 4, then 0 with wrap at cycle 8, state=10. Further ticks and steps leave addr=0; run=0 -> state=00.
- Simultaneous load (load_addr=2) and step_rise in IDLE -> addr=2, no increment. Load during RUN at prescaler=2 -> addr=load_addr, next advance 4 cycles later.
- reset_n pulsed low asynchronously mid-RUN at addr=3, prescaler=3 -> addr=0, state=00, addr_valid=0 immediately. No advance after release until run is re-asserted, then TICK_DIV cycles.
